// File: rtl/imem_wb_loader.sv
// Wishbone master that streams a length-prefixed byte image into instruction SRAM,
// one single-beat 32-bit write per assembled little-endian word.
module imem_wb_loader #(
    parameter logic [7:0]  BASE_ADDR   = 8'h00,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n,
    input  logic        start_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_data_i,
    output logic        byte_ready_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [7:0]  wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic        wbm_ack_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [8:0]  words_written_o
);

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StCollect,
        StWrite,
        StDone,
        StError
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [8:0]  n_q, n_d;
    logic [8:0]  cnt_q, cnt_d;
    logic [7:0]  tmo_q, tmo_d;
    logic [7:0]  adr_q, adr_d;
    logic [31:0] dat_q, dat_d;

    logic in_write;
    logic take;
    logic [8:0] cnt_inc;

    assign in_write = (state_q == StWrite);
    assign byte_ready_o = (state_q == StHdr) || (state_q == StCollect);
    assign take = byte_valid_i && byte_ready_o;
    assign cnt_inc = cnt_q + 9'd1;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q <= StIdle;
            idx_q   <= 2'd0;
            n_q     <= 9'd0;
            cnt_q   <= 9'd0;
            tmo_q   <= 8'd0;
            adr_q   <= 8'd0;
            dat_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        unique case (state_q)
            StIdle, StDone, StError: begin
                if (start_i) begin
                    state_d = StHdr;
                    cnt_d   = 9'd0;
                    adr_d   = BASE_ADDR;
                end
            end
            StHdr: begin
                if (take) begin
                    // Length byte L encodes L+1 words, so 8'hFF means a full 256-word image.
                    n_d     = {1'b0, byte_data_i} + 9'd1;
                    idx_d   = 2'd0;
                    state_d = StCollect;
                end
            end
            StCollect: begin
                if (take) begin
                    dat_d[{idx_q, 3'b000} +: 8] = byte_data_i;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = StWrite;
                        tmo_d   = 8'd0;
                    end
                end
            end
            StWrite: begin
                if (wbm_ack_i) begin
                    cnt_d   = cnt_inc;
                    adr_d   = adr_q + 8'd1;
                    state_d = (cnt_inc == n_q) ? StDone : StCollect;
                end else if (tmo_q == 8'(ACK_TIMEOUT - 1)) begin
                    state_d = StError;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign wbm_cyc_o       = in_write;
    assign wbm_stb_o       = in_write;
    assign wbm_we_o        = in_write;
    assign wbm_sel_o       = {4{in_write}};
    assign wbm_adr_o       = adr_q;
    assign wbm_dat_o       = dat_q;
    assign busy_o          = byte_ready_o || in_write;
    assign done_o          = (state_q == StDone);
    assign err_o           = (state_q == StError);
    assign words_written_o = cnt_q;

endmodule

// File: tb/tb_imem_wb_loader.sv
// Randomized bench for imem_wb_loader: a byte feeder, a Wishbone slave with programmable
// ack latency, and an expected-image model compared write by write.
module tb_imem_wb_loader;

    localparam logic [7:0] BASE  = 8'h10;
    localparam int         TMO   = 16;
    localparam int         NEVER = -1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        valid;
    logic [7:0]  data;
    logic        ready;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [7:0]  adr;
    logic [31:0] dat;
    logic        ack = 1'b0;
    logic        busy, done, err;
    logic [8:0]  words;

    int n_checks = 0;
    int n_errs   = 0;

    int ack_dly  = 0;
    int stb_cnt  = 0;
    int last_run = 0;
    int bp_viol  = 0;
    int bus_viol = 0;
    logic [39:0] wr_q[$];
    logic [7:0]  tx_q[$];

    imem_wb_loader #(
        .BASE_ADDR  (BASE),
        .ACK_TIMEOUT(TMO)
    ) u_dut (
        .wb_clk_i       (clk),
        .wb_rst_n       (rst_n),
        .start_i        (start),
        .byte_valid_i   (valid),
        .byte_data_i    (data),
        .byte_ready_o   (ready),
        .wbm_cyc_o      (cyc),
        .wbm_stb_o      (stb),
        .wbm_we_o       (we),
        .wbm_sel_o      (sel),
        .wbm_adr_o      (adr),
        .wbm_dat_o      (dat),
        .wbm_ack_i      (ack),
        .busy_o         (busy),
        .done_o         (done),
        .err_o          (err),
        .words_written_o(words)
    );

    always #5 clk = ~clk;

    // Slave: ack after ack_dly stb cycles; random stray acks while stb is low.
    always @(negedge clk) begin
        if (stb) begin
            if ((ack_dly != NEVER) && (stb_cnt >= ack_dly)) begin
                ack <= 1'b1;
                wr_q.push_back({adr, dat});
            end else begin
                ack <= 1'b0;
            end
            stb_cnt <= stb_cnt + 1;
            if (ready) bp_viol <= bp_viol + 1;
            if (!we || sel != 4'hF || !cyc) bus_viol <= bus_viol + 1;
        end else begin
            if (stb_cnt != 0) last_run <= stb_cnt;
            stb_cnt <= 0;
            ack <= ($urandom_range(0, 3) == 0);
            if (sel != 4'h0 || we || cyc) bus_viol <= bus_viol + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [39:0] got, input logic [39:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic feed(input int gap_pct, input int start_at, output bit ok);
        int  budget = 20000;
        int  k = 0;
        bit  pulsed = 1'b0;
        while (tx_q.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
            if (!pulsed && start_at >= 0 && k == start_at) begin
                start  = 1'b1;
                pulsed = 1'b1;
            end else begin
                start = 1'b0;
            end
            if ($urandom_range(0, 99) < gap_pct) begin
                valid = 1'b0;
            end else begin
                valid = 1'b1;
                data  = tx_q[0];
            end
            if (valid && ready) begin
                void'(tx_q.pop_front());
                k++;
            end
        end
        @(negedge clk);
        valid = 1'b0;
        start = 1'b0;
        ok = (tx_q.size() == 0);
    endtask

    task automatic wait_end(output bit ok);
        int b = 3000;
        while (!(done || err) && b > 0) begin
            @(negedge clk);
            b--;
        end
        ok = done || err;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        valid = (tx_q.size() > 0);
        if (tx_q.size() > 0) data = tx_q[0];
        @(negedge clk);
        start = 1'b0;
        valid = 1'b0;
    endtask

    // mode 0: random words, 1: incrementing byte pattern, 2: constant 32'h13
    task automatic do_load(input int len, input int dly, input int gap, input int start_at,
                           input int mode, input bit with_start, input string tag);
        logic [31:0] exp_w[$];
        logic [31:0] w;
        logic [7:0]  lb;
        logic [7:0]  ea;
        int          n = len + 1;
        int          base = wr_q.size();
        int          bp0 = bp_viol;
        int          bus0 = bus_viol;
        bit          ok;
        ack_dly = dly;
        tx_q.delete();
        lb = 8'(len);
        tx_q.push_back(lb);
        for (int i = 0; i < n; i++) begin
            if (mode == 0) w = $urandom;
            else if (mode == 1) w = 32'(i) * 32'h04040404 + 32'h03020100;
            else w = 32'h00000013;
            exp_w.push_back(w);
            for (int b = 0; b < 4; b++) tx_q.push_back(w[8*b +: 8]);
        end
        if (with_start) pulse_start();
        feed(gap, start_at, ok);
        check_eq({tag, " feed"}, 40'(ok), 40'd1);
        wait_end(ok);
        check_eq({tag, " end"}, 40'(ok), 40'd1);
        @(negedge clk);
        check_eq({tag, " done"}, 40'({done, err, busy}), 40'b100);
        check_eq({tag, " words"}, 40'(words), 40'(n));
        check_eq({tag, " nwr"}, 40'(wr_q.size() - base), 40'(n));
        check_eq({tag, " bp"}, 40'(bp_viol - bp0), 40'd0);
        check_eq({tag, " bus"}, 40'(bus_viol - bus0), 40'd0);
        for (int i = 0; i < n && base + i < wr_q.size(); i++) begin
            ea = BASE + 8'(i);
            check_eq({tag, " wr"}, wr_q[base + i], {ea, exp_w[i]});
        end
    endtask

    initial begin
        bit ok;
        int base;
        rst_n = 1'b0;
        start = 1'b0;
        valid = 1'b0;
        data  = 8'h00;
        repeat (2) @(negedge clk);
        check_eq("rst bus", 40'({cyc, stb, we, sel, ready}), 40'd0);
        check_eq("rst adr_dat", {adr, dat}, 40'd0);
        check_eq("rst status", 40'({busy, done, err, words}), 40'd0);
        rst_n = 1'b1;

        do_load(0, 0, 0, -1, 2, 1'b1, "single");
        for (int r = 0; r < 4; r++)
            do_load(int'($urandom_range(0, 6)), int'($urandom_range(0, 3)), 40, -1, 0, 1'b1,
                    "rand");
        do_load(255, 0, 0, -1, 1, 1'b1, "full");
        do_load(3, 5, 0, -1, 0, 1'b1, "backpr");
        do_load(2, 1, 20, 5, 0, 1'b1, "st_coll");

        // Slave never acks: expect exactly TMO strobe cycles, then ERROR.
        ack_dly = NEVER;
        base = wr_q.size();
        tx_q.delete();
        tx_q.push_back(8'h01);
        for (int b = 0; b < 4; b++) tx_q.push_back(8'($urandom));
        pulse_start();
        feed(0, -1, ok);
        wait_end(ok);
        check_eq("tmo end", 40'(ok), 40'd1);
        @(negedge clk);
        check_eq("tmo status", 40'({done, err, busy, cyc, stb}), 40'b01000);
        check_eq("tmo words", 40'(words), 40'd0);
        check_eq("tmo run", 40'(last_run), 40'(TMO));
        check_eq("tmo nwr", 40'(wr_q.size() - base), 40'd0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("tmo restart", 40'({err, busy, ready}), 40'b011);
        do_load(0, 0, 0, -1, 0, 1'b0, "after_err");

        // Asynchronous reset between edges while stb is high.
        ack_dly = 5;
        tx_q.delete();
        tx_q.push_back(8'h00);
        for (int b = 0; b < 4; b++) tx_q.push_back(8'($urandom));
        pulse_start();
        feed(0, -1, ok);
        for (int b = 0; b < 50 && !stb; b++) @(negedge clk);
        check_eq("arst stb seen", 40'(stb), 40'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst bus", 40'({cyc, stb, we, sel, busy, ready}), 40'd0);
        check_eq("arst stat", 40'({done, err, words, adr}), 40'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("arst idle", 40'({busy, done, err, ready}), 40'd0);
        do_load(0, 0, 0, -1, 0, 1'b1, "post_rst");

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
